data_memory_hs: RTL and testbench

DATA_MEMORY_HS -- requirements
Module: data_memory_hs

---
 rtl/data_memory_hs_if.sv | 24 ++
 rtl/data_memory_hs.sv | 107 ++++++++++
 tb/tb_data_memory_hs.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_hs_if.sv
// rtl/data_memory_hs_if.sv - request/response bus for the handshaked data memory
interface data_memory_hs_if #(
    parameter int DATA_W = 32
);
    logic                  req;
    logic                  we;
    logic [31:0]           adr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   be;
    logic                  busy;
    logic                  rvalid;
    logic [DATA_W-1:0]     rdata;
    logic                  err;

    modport master (
        output req, we, adr, wdata, be,
        input  busy, rvalid, rdata, err
    );

    modport slave (
        input  req, we, adr, wdata, be,
        output busy, rvalid, rdata, err
    );
endinterface

// File: rtl/data_memory_hs.sv
// rtl/data_memory_hs.sv - byte-enabled word memory with fixed-latency reads and error responses
module data_memory_hs #(
    parameter int          DATA_W    = 32,
    parameter int          DEPTH     = 512,
    parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
    parameter int          RD_LAT    = 2
) (
    input  logic            clk,
    input  logic            rst,
    data_memory_hs_if.slave bus
);
    localparam int          NB    = DATA_W / 8;
    localparam int          IDX_W = $clog2(DEPTH);
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);

    typedef enum logic {
        IDLE,
        RD_WAIT
    } state_t;

    state_t            state, state_next;
    logic [2:0]        cnt, cnt_next;
    logic [IDX_W-1:0]  idx, idx_q, idx_next, fire_idx;
    logic              illegal, illegal_q, illegal_next, fire_illegal;
    logic              accept, fire;
    logic [31:0]       offset;
    logic              unused_offset_bits;
    logic [DATA_W-1:0] mem [DEPTH];

    assign offset             = bus.adr - BASE_ADDR;
    assign idx                = offset[IDX_W+1:2];
    assign unused_offset_bits = ^{offset[31:IDX_W+2], offset[1:0]};
    assign illegal            = (bus.adr[1:0] != 2'b00) || (bus.adr < BASE_ADDR)
                              || ({1'b0, bus.adr} >= LIMIT);
    assign accept             = bus.req && (state == IDLE);
    assign bus.busy           = (state == RD_WAIT);

    // cnt counts the edges still to go before the response edge; the acceptance
    // edge itself is the first of the RD_LAT, so RD_LAT=1 answers immediately.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        idx_next     = idx_q;
        illegal_next = illegal_q;
        fire         = 1'b0;
        fire_idx     = idx_q;
        fire_illegal = illegal_q;
        case (state)
            IDLE: begin
                if (accept && !bus.we) begin
                    idx_next     = idx;
                    illegal_next = illegal;
                    fire_idx     = idx;
                    fire_illegal = illegal;
                    if (RD_LAT <= 1) begin
                        fire     = 1'b1;
                        cnt_next = 3'd0;
                    end else begin
                        state_next = RD_WAIT;
                        cnt_next   = 3'(RD_LAT - 1);
                    end
                end
            end
            RD_WAIT: begin
                cnt_next = cnt - 3'd1;
                if (cnt == 3'd1) begin
                    fire       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            idx_q      <= '0;
            illegal_q  <= 1'b0;
            bus.rvalid <= 1'b0;
            bus.err    <= 1'b0;
            bus.rdata  <= '0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            idx_q      <= idx_next;
            illegal_q  <= illegal_next;
            bus.rvalid <= fire;
            bus.err    <= fire ? fire_illegal : (accept && bus.we && illegal);
            if (fire) begin
                bus.rdata <= fire_illegal ? '0 : mem[fire_idx];
            end
        end
    end

    // Memory is not reset; a read on the same edge sees the pre-write word.
    always_ff @(posedge clk) begin
        if (!rst && accept && bus.we && !illegal) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.be[i]) begin
                    mem[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_data_memory_hs.sv
// tb/tb_data_memory_hs.sv - self-checking bench for data_memory_hs
module tb_data_memory_hs;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic        sweep_en = 1'b0;
    logic [31:0] adr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [3:0]  be = 4'h0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    data_memory_hs_if #(.DATA_W(32)) bus1 ();
    data_memory_hs_if #(.DATA_W(32)) bus2 ();
    data_memory_hs_if #(.DATA_W(32)) bus3 ();
    data_memory_hs_if #(.DATA_W(32)) bus4 ();

    assign bus2.req = req;
    assign bus2.we = we;
    assign bus2.adr = adr;
    assign bus2.wdata = wdata;
    assign bus2.be = be;
    assign bus1.req = req & sweep_en;
    assign bus1.we = we;
    assign bus1.adr = adr;
    assign bus1.wdata = wdata;
    assign bus1.be = be;
    assign bus3.req = req & sweep_en;
    assign bus3.we = we;
    assign bus3.adr = adr;
    assign bus3.wdata = wdata;
    assign bus3.be = be;
    assign bus4.req = req & sweep_en;
    assign bus4.we = we;
    assign bus4.adr = adr;
    assign bus4.wdata = wdata;
    assign bus4.be = be;

    data_memory_hs #(.DATA_W(32), .DEPTH(512), .BASE_ADDR(32'h2000), .RD_LAT(1))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));
    data_memory_hs #(.DATA_W(32), .DEPTH(512), .BASE_ADDR(32'h2000), .RD_LAT(2))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));
    data_memory_hs #(.DATA_W(32), .DEPTH(512), .BASE_ADDR(32'h2000), .RD_LAT(3))
        dut3 (.clk(clk), .rst(rst), .bus(bus3));
    data_memory_hs #(.DATA_W(32), .DEPTH(512), .BASE_ADDR(32'h2000), .RD_LAT(4))
        dut4 (.clk(clk), .rst(rst), .bus(bus4));

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  b;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t        vt [14];
    logic [31:0] mdl [16];
    logic [31:0] last_rd;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Issues one request on the RD_LAT=2 instance, holding req until accepted,
    // and returns the response: rdata/err plus the rvalid cycle count for reads.
    task automatic do_op(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b, output logic [31:0] rd, output logic e,
                         output int lat);
        bit acc = 1'b0;
        req = 1'b1; we = w; adr = a; wdata = d; be = b;
        for (int n = 0; n < 20 && !acc; n++) begin
            @(negedge clk);
            acc = !bus2.busy;
            @(posedge clk); #1;
        end
        req = 1'b0;
        check("accept", 32'(acc), 32'd1);
        rd = 32'h0; e = 1'b0; lat = 0;
        if (w) begin
            @(negedge clk);
            e = bus2.err;
            rd = bus2.rdata;
            check("wr_no_rvalid", 32'(bus2.rvalid), 32'd0);
        end else begin
            for (int n = 1; n <= 10; n++) begin
                @(negedge clk);
                if (bus2.rvalid) begin
                    lat = n; rd = bus2.rdata; e = bus2.err;
                    check("rvalid_busy", 32'(bus2.busy), 32'd0);
                    break;
                end
                check("wait_busy", 32'(bus2.busy), 32'd1);
            end
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] b);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    initial begin
        logic [31:0] rd, a, d, v1;
        logic [3:0]  b;
        logic        e;
        int          lat, k, l1, l2, l3, l4, nrv;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(bus2.busy), 32'd0);
        check("rst_rvalid", 32'(bus2.rvalid), 32'd0);
        check("rst_err", 32'(bus2.err), 32'd0);
        check("rst_rdata", bus2.rdata, 32'd0);
        @(posedge clk); #1;

        vt[0]  = '{1'b1, 32'h2000, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0};
        vt[1]  = '{1'b0, 32'h2000, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0};
        vt[2]  = '{1'b1, 32'h2004, 32'h11223344, 4'hF, 32'h0, 1'b0};
        vt[3]  = '{1'b1, 32'h2004, 32'hAABBCCDD, 4'h5, 32'h0, 1'b0};
        vt[4]  = '{1'b0, 32'h2004, 32'hFFFFFFFF, 4'hF, 32'h11BB33DD, 1'b0};
        vt[5]  = '{1'b0, 32'h1FFC, 32'h0, 4'h0, 32'h0, 1'b1};
        vt[6]  = '{1'b0, 32'h2001, 32'h0, 4'h0, 32'h0, 1'b1};
        vt[7]  = '{1'b0, 32'h2800, 32'h0, 4'h0, 32'h0, 1'b1};
        vt[8]  = '{1'b1, 32'h2800, 32'h55555555, 4'hF, 32'h0, 1'b1};
        vt[9]  = '{1'b1, 32'h27FC, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0};
        vt[10] = '{1'b0, 32'h27FC, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0};
        vt[11] = '{1'b0, 32'h2000, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0};
        vt[12] = '{1'b1, 32'h2004, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0};
        vt[13] = '{1'b0, 32'h2004, 32'h0, 4'h0, 32'h11BB33DD, 1'b0};
        last_rd = 32'h0;
        for (int i = 0; i < 14; i++) begin
            do_op(vt[i].w, vt[i].a, vt[i].d, vt[i].b, rd, e, lat);
            check($sformatf("vec%0d_err", i), 32'(e), 32'(vt[i].exp_err));
            if (vt[i].w) begin
                check($sformatf("vec%0d_hold", i), rd, last_rd);
            end else begin
                check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
                check($sformatf("vec%0d_lat", i), 32'(lat), 32'd2);
                last_rd = vt[i].exp_rd;
            end
        end

        for (int i = 0; i < 16; i++) begin
            mdl[i] = $urandom;
            do_op(1'b1, 32'h2000 + 32'(4 * i), mdl[i], 4'hF, rd, e, lat);
            check("init_err", 32'(e), 32'd0);
        end

        for (int i = 0; i < 4; i++) begin
            mdl[i] = $urandom;
            req = 1'b1; we = 1'b1; adr = 32'h2000 + 32'(4 * i); wdata = mdl[i]; be = 4'hF;
            @(negedge clk);
            check("b2b_busy", 32'(bus2.busy), 32'd0);
            @(posedge clk); #1;
        end
        req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_op(1'b0, 32'h2000 + 32'(4 * i), 32'h0, 4'h0, rd, e, lat);
            check("b2b_rdata", rd, mdl[i]);
        end

        req = 1'b1; we = 1'b0; adr = 32'h2010;
        @(negedge clk);
        check("held_a_accept", 32'(bus2.busy), 32'd0);
        @(posedge clk); #1;
        adr = 32'h2014;
        @(negedge clk);
        check("held_busy", 32'(bus2.busy), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("held_a_rvalid", 32'(bus2.rvalid), 32'd1);
        check("held_a_busy", 32'(bus2.busy), 32'd0);
        check("held_a_rdata", bus2.rdata, mdl[4]);
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        check("held_b_busy", 32'(bus2.busy), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("held_b_rvalid", 32'(bus2.rvalid), 32'd1);
        check("held_b_rdata", bus2.rdata, mdl[5]);
        last_rd = mdl[5];
        @(posedge clk); #1;

        for (int i = 0; i < 150; i++) begin
            k = $urandom_range(0, 15);
            d = $urandom;
            b = 4'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                case ($urandom_range(0, 3))
                    0: a = 32'h1FFC - 32'(4 * $urandom_range(0, 50));
                    1: a = 32'h2000 + 32'(4 * k) + 32'($urandom_range(1, 3));
                    2: a = 32'h2800 + 32'(4 * $urandom_range(0, 100));
                    default: a = 32'hFFFF_FFFC;
                endcase
                do_op(i[0], a, d, b, rd, e, lat);
                check("rnd_ill_err", 32'(e), 32'd1);
                if (!i[0]) begin
                    check("rnd_ill_rdata", rd, 32'h0);
                    last_rd = 32'h0;
                end
            end else if ($urandom_range(0, 1) == 0) begin
                do_op(1'b1, 32'h2000 + 32'(4 * k), d, b, rd, e, lat);
                mdl[k] = merge(mdl[k], d, b);
                check("rnd_wr_err", 32'(e), 32'd0);
                check("rnd_wr_hold", rd, last_rd);
            end else begin
                do_op(1'b0, 32'h2000 + 32'(4 * k), d, b, rd, e, lat);
                check("rnd_rd_rdata", rd, mdl[k]);
                check("rnd_rd_err", 32'(e), 32'd0);
                check("rnd_rd_lat", 32'(lat), 32'd2);
                last_rd = mdl[k];
            end
        end

        sweep_en = 1'b1;
        mdl[0] = 32'h0BADF00D;
        req = 1'b1; we = 1'b1; adr = 32'h2000; wdata = mdl[0]; be = 4'hF;
        @(posedge clk); #1;
        we = 1'b0;
        @(posedge clk); #1;
        req = 1'b0;
        l1 = 0; l2 = 0; l3 = 0; l4 = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (bus1.rvalid && l1 == 0) begin l1 = n; check("sw1_rdata", bus1.rdata, mdl[0]); end
            if (bus2.rvalid && l2 == 0) l2 = n;
            if (bus3.rvalid && l3 == 0) l3 = n;
            if (bus4.rvalid && l4 == 0) begin l4 = n; check("sw4_rdata", bus4.rdata, mdl[0]); end
        end
        check("sweep_lat1", 32'(l1), 32'd1);
        check("sweep_lat2", 32'(l2), 32'd2);
        check("sweep_lat3", 32'(l3), 32'd3);
        check("sweep_lat4", 32'(l4), 32'd4);
        @(posedge clk); #1;

        req = 1'b1; we = 1'b0; adr = 32'h2000;
        @(posedge clk); #1;
        rst = 1'b1;
        we = 1'b1; wdata = 32'hFFFF_FFFF; be = 4'hF;
        @(posedge clk); #1;
        rst = 1'b0; req = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 32'(bus3.busy), 32'd0);
        check("mid_rst_rvalid", 32'(bus3.rvalid), 32'd0);
        check("mid_rst_rdata", bus3.rdata, 32'd0);
        check("mid_rst_rdata1", bus1.rdata, 32'd0);
        nrv = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            nrv += int'(bus2.rvalid) + int'(bus3.rvalid) + int'(bus4.rvalid);
        end
        check("mid_rst_no_rvalid", 32'(nrv), 32'd0);
        @(posedge clk); #1;

        do_op(1'b0, 32'h2000, 32'h0, 4'h0, rd, e, lat);
        v1 = bus1.rdata;
        check("rst_prio_rdata2", rd, mdl[0]);
        check("rst_prio_rdata1", v1, mdl[0]);
        sweep_en = 1'b0;
        repeat (6) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
